mem_perf_monitor: RTL and testbench

Synthesizable, parametrised performance and protocol monitor for the cache/memory system, tracking NUM_CH independent request channels (e.g. instruction and data ports of mem_system). It sits beside the memory system, observing each channel's Rd/Wr/Done/CacheHit. It counts requests, replies and hits, and checks hit and miss latency bounds. It also detects dropped or hung requests. Counters are read out through a registered select port, so benches and the processor debug path share one view.

---
 rtl/mem_perf_pkg.sv | 26 ++
 rtl/mem_perf_chan.sv | 152 +++++++++++++++
 rtl/mem_perf_monitor.sv | 77 +++++++
 tb/tb_mem_perf_monitor.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mem_perf_pkg.sv
// Shared types and constants for the memory performance monitor.
package mem_perf_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } chan_state_e;

    localparam logic [2:0] CTR_REQ  = 3'd0;
    localparam logic [2:0] CTR_REP  = 3'd1;
    localparam logic [2:0] CTR_HIT  = 3'd2;
    localparam logic [2:0] CTR_LSUM = 3'd3;
    localparam logic [2:0] CTR_PERR = 3'd4;
    localparam logic [2:0] CTR_DROP = 3'd5;
    localparam logic [2:0] CTR_LMAX = 3'd6;
    localparam logic [2:0] CTR_CYC  = 3'd7;

    localparam int NUM_CHAN_CTRS = 7;

    localparam int DEF_HIT_MAX  = 2;
    localparam int DEF_MISS_MIN = 3;
    localparam int DEF_MISS_MAX = 20;
    localparam int DEF_TIMEOUT  = 64;

endpackage

// File: rtl/mem_perf_chan.sv
// One monitored channel: request FSM, latency tracking and saturating counters.
module mem_perf_chan
    import mem_perf_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int HIT_MAX  = DEF_HIT_MAX,
    parameter int MISS_MIN = DEF_MISS_MIN,
    parameter int MISS_MAX = DEF_MISS_MAX,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  clear,
    input  logic                                  rd,
    input  logic                                  wr,
    input  logic                                  done,
    input  logic                                  cache_hit,
    output logic [NUM_CHAN_CTRS-1:0][CNT_W-1:0]   ctrs,
    output logic                                  err,
    output logic                                  busy
);

    localparam int LAT_W = $clog2(TIMEOUT + 1);
    localparam int SUM_W = ((CNT_W > LAT_W) ? CNT_W : LAT_W) + 2;
    localparam logic [CNT_W-1:0] CNT_ALL = {CNT_W{1'b1}};

    // Add with clamp at the counter's all-ones value.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [SUM_W-1:0] b);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + b;
        return (s > SUM_W'(CNT_ALL)) ? CNT_ALL : s[CNT_W-1:0];
    endfunction

    chan_state_e state, state_nx;
    logic [LAT_W-1:0] lat, lat_nx, cur_lat, done_lat;
    logic             req, req_inc, rep_inc, hit_inc, drop_inc;
    logic             proto_bad, lat_bad, err_set;
    logic [1:0]       perf_inc;
    logic [CNT_W-1:0] lat_cap;
    logic [CNT_W-1:0] requests, replies, hits, lat_sum, perf_err, dropped, lat_max;

    assign req     = rd | wr;
    assign busy    = (state != IDLE);
    assign lat_cap = sat_add('0, SUM_W'(done_lat));

    // Next-state, latency and per-cycle counting events for this channel.
    always_comb begin
        state_nx  = state;
        lat_nx    = lat;
        req_inc   = 1'b0;
        rep_inc   = 1'b0;
        hit_inc   = 1'b0;
        drop_inc  = 1'b0;
        proto_bad = 1'b0;
        lat_bad   = 1'b0;
        done_lat  = '0;
        cur_lat   = (lat >= LAT_W'(TIMEOUT)) ? LAT_W'(TIMEOUT) : lat + LAT_W'(1);
        case (state)
            IDLE: begin
                if (req) begin
                    req_inc   = 1'b1;
                    lat_nx    = LAT_W'(1);
                    proto_bad = rd & wr;
                    if (done) begin
                        rep_inc  = 1'b1;
                        done_lat = LAT_W'(1);
                    end else begin
                        state_nx = WAIT;
                    end
                end else if (done) begin
                    proto_bad = 1'b1;
                end
            end
            WAIT: begin
                if (done) begin
                    rep_inc  = 1'b1;
                    done_lat = cur_lat;
                    state_nx = IDLE;
                end else if (!req) begin
                    drop_inc = 1'b1;
                    state_nx = IDLE;
                end else if (cur_lat == LAT_W'(TIMEOUT)) begin
                    drop_inc = 1'b1;
                    lat_nx   = cur_lat;
                    state_nx = DRAIN;
                end else begin
                    lat_nx = cur_lat;
                end
            end
            DRAIN: begin
                if (!req) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (rep_inc) begin
            if (cache_hit) begin
                hit_inc = 1'b1;
                lat_bad = (int'(done_lat) > HIT_MAX);
            end else begin
                lat_bad = (int'(done_lat) < MISS_MIN) || (int'(done_lat) > MISS_MAX);
            end
        end
        perf_inc = {1'b0, proto_bad} + {1'b0, lat_bad};
        err_set  = proto_bad | lat_bad | drop_inc;
    end

    // FSM state and latency register; reset or clear aborts any request.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state <= IDLE;
            lat   <= '0;
        end else begin
            state <= state_nx;
            lat   <= lat_nx;
        end
    end

    // Saturating statistics counters and the sticky error flag.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            requests <= '0;
            replies  <= '0;
            hits     <= '0;
            lat_sum  <= '0;
            perf_err <= '0;
            dropped  <= '0;
            lat_max  <= '0;
            err      <= 1'b0;
        end else begin
            if (req_inc) requests <= sat_add(requests, SUM_W'(1));
            if (rep_inc) begin
                replies <= sat_add(replies, SUM_W'(1));
                lat_sum <= sat_add(lat_sum, SUM_W'(done_lat));
                if (lat_cap > lat_max) lat_max <= lat_cap;
            end
            if (hit_inc) hits <= sat_add(hits, SUM_W'(1));
            if (perf_inc != 2'd0) perf_err <= sat_add(perf_err, SUM_W'(perf_inc));
            if (drop_inc) dropped <= sat_add(dropped, SUM_W'(1));
            if (err_set) err <= 1'b1;
        end
    end

    assign ctrs[CTR_REQ]  = requests;
    assign ctrs[CTR_REP]  = replies;
    assign ctrs[CTR_HIT]  = hits;
    assign ctrs[CTR_LSUM] = lat_sum;
    assign ctrs[CTR_PERR] = perf_err;
    assign ctrs[CTR_DROP] = dropped;
    assign ctrs[CTR_LMAX] = lat_max;

endmodule

// File: rtl/mem_perf_monitor.sv
// Multi-channel memory performance monitor with global cycle counter and registered readout.
module mem_perf_monitor
    import mem_perf_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int CNT_W    = 32,
    parameter int HIT_MAX  = DEF_HIT_MAX,
    parameter int MISS_MIN = DEF_MISS_MIN,
    parameter int MISS_MAX = DEF_MISS_MAX,
    parameter int TIMEOUT  = DEF_TIMEOUT,
    localparam int SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [NUM_CH-1:0] Rd,
    input  logic [NUM_CH-1:0] Wr,
    input  logic [NUM_CH-1:0] Done,
    input  logic [NUM_CH-1:0] CacheHit,
    input  logic [SEL_W-1:0]  sel_ch,
    input  logic [2:0]        sel_ctr,
    output logic [CNT_W-1:0]  rd_data,
    output logic [NUM_CH-1:0] err,
    output logic [NUM_CH-1:0] busy
);

    logic [NUM_CH-1:0][NUM_CHAN_CTRS-1:0][CNT_W-1:0] bank;
    logic [CNT_W-1:0] cyc, rd_next;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        mem_perf_chan #(
            .CNT_W    (CNT_W),
            .HIT_MAX  (HIT_MAX),
            .MISS_MIN (MISS_MIN),
            .MISS_MAX (MISS_MAX),
            .TIMEOUT  (TIMEOUT)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .clear     (clear),
            .rd        (Rd[g]),
            .wr        (Wr[g]),
            .done      (Done[g]),
            .cache_hit (CacheHit[g]),
            .ctrs      (bank[g]),
            .err       (err[g]),
            .busy      (busy[g])
        );
    end

    // Global free-running cycle counter, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst || clear) cyc <= '0;
        else if (cyc != {CNT_W{1'b1}}) cyc <= cyc + CNT_W'(1);
    end

    // Readout select; out-of-range channels read as zero.
    always_comb begin
        rd_next = '0;
        if (sel_ctr == CTR_CYC) begin
            rd_next = cyc;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int k = 0; k < NUM_CHAN_CTRS; k++) begin
                    if (sel_ch == SEL_W'(c) && sel_ctr == 3'(k)) rd_next = bank[c][k];
                end
            end
        end
    end

    // Registered readout, so values lag the select by one cycle.
    always_ff @(posedge clk) begin
        if (rst || clear) rd_data <= '0;
        else rd_data <= rd_next;
    end

endmodule

// File: tb/tb_mem_perf_monitor.sv
// Directed testbench for mem_perf_monitor; a 4-bit-counter copy covers saturation.
module tb_mem_perf_monitor;

    logic        clk = 1'b0;
    logic        rst, clear;
    logic [1:0]  Rd, Wr, Done, CacheHit;
    logic [0:0]  sel_ch;
    logic [2:0]  sel_ctr;
    logic [31:0] rd_data;
    logic [1:0]  err, busy;
    logic [3:0]  rd_data4;
    logic [1:0]  err4, busy4;

    int vectors     = 0;
    int miscompares = 0;

    mem_perf_monitor dut (
        .clk(clk), .rst(rst), .clear(clear), .Rd(Rd), .Wr(Wr), .Done(Done),
        .CacheHit(CacheHit), .sel_ch(sel_ch), .sel_ctr(sel_ctr),
        .rd_data(rd_data), .err(err), .busy(busy)
    );

    mem_perf_monitor #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .clear(clear), .Rd(Rd), .Wr(Wr), .Done(Done),
        .CacheHit(CacheHit), .sel_ch(sel_ch), .sel_ctr(sel_ctr),
        .rd_data(rd_data4), .err(err4), .busy(busy4)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] r, input logic [1:0] w,
                                 input logic [1:0] d, input logic [1:0] h);
        Rd = r; Wr = w; Done = d; CacheHit = h;
        tick();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic readCtr(input int ch, input int ctr, input logic [31:0] expected,
                           input string tag);
        sel_ch  = 1'(ch);
        sel_ctr = 3'(ctr);
        tick();
        checkOutput(tag, rd_data, expected);
    endtask

    task automatic pulseClear();
        Rd = '0; Wr = '0; Done = '0; CacheHit = '0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0;
        Rd = '0; Wr = '0; Done = '0; CacheHit = '0;
        sel_ch = '0; sel_ctr = '0;
        tick();
        tick();
        rst = 1'b0;
        $display("[TB] reset released");
        checkOutput("reset_rd_data", rd_data, 0);
        checkOutput("reset_err", 32'(err), 0);
        checkOutput("reset_busy", 32'(busy), 0);
        repeat (3) applyStimulus(2'b00, 2'b00, 2'b00, 2'b00);
        readCtr(0, 7, 3, "cycle_counter");

        // Ch0 read hit completing at latency 2
        applyStimulus(2'b01, 2'b00, 2'b00, 2'b00);
        checkOutput("hit_busy_wait", 32'(busy), 32'b01);
        applyStimulus(2'b01, 2'b00, 2'b01, 2'b01);
        checkOutput("hit_busy_done", 32'(busy), 0);
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00);
        readCtr(0, 0, 1, "hit_requests");
        readCtr(0, 1, 1, "hit_replies");
        readCtr(0, 2, 1, "hit_hits");
        readCtr(0, 6, 2, "hit_lat_max");
        readCtr(0, 3, 2, "hit_lat_sum");
        checkOutput("hit_err", 32'(err), 0);

        // Ch1 write miss at latency 21, above the miss bound
        applyStimulus(2'b00, 2'b10, 2'b00, 2'b00);
        repeat (19) applyStimulus(2'b00, 2'b10, 2'b00, 2'b00);
        applyStimulus(2'b00, 2'b10, 2'b10, 2'b00);
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00);
        checkOutput("slow_miss_err", 32'(err), 32'b10);
        readCtr(1, 4, 1, "slow_miss_perf_err");
        readCtr(1, 1, 1, "slow_miss_replies");
        readCtr(1, 3, 21, "slow_miss_lat_sum");
        readCtr(0, 1, 1, "slow_miss_ch0_replies");
        readCtr(0, 4, 0, "slow_miss_ch0_perf_err");

        // Ch0 request withdrawn after 5 cycles
        pulseClear();
        checkOutput("clear_err", 32'(err), 0);
        repeat (5) applyStimulus(2'b01, 2'b00, 2'b00, 2'b00);
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00);
        checkOutput("withdraw_busy", 32'(busy), 0);
        checkOutput("withdraw_err", 32'(err), 32'b01);
        readCtr(0, 5, 1, "withdraw_dropped");
        readCtr(0, 1, 0, "withdraw_replies");
        readCtr(0, 0, 1, "withdraw_requests");

        // Ch0 request hung past the timeout, then drained
        pulseClear();
        repeat (64) applyStimulus(2'b01, 2'b00, 2'b00, 2'b00);
        checkOutput("timeout_busy", 32'(busy), 32'b01);
        readCtr(0, 5, 1, "timeout_dropped");
        repeat (4) applyStimulus(2'b01, 2'b00, 2'b00, 2'b00);
        applyStimulus(2'b01, 2'b00, 2'b01, 2'b01);
        applyStimulus(2'b01, 2'b00, 2'b00, 2'b00);
        checkOutput("drain_busy", 32'(busy), 32'b01);
        readCtr(0, 1, 0, "drain_replies");
        checkOutput("drain_err", 32'(err), 32'b01);
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00);
        checkOutput("drain_exit_busy", 32'(busy), 0);

        // Rd and Wr together, a spurious Done, and a slow hit
        pulseClear();
        applyStimulus(2'b01, 2'b01, 2'b01, 2'b01);
        applyStimulus(2'b00, 2'b00, 2'b10, 2'b00);
        checkOutput("protocol_err", 32'(err), 32'b11);
        applyStimulus(2'b01, 2'b00, 2'b00, 2'b00);
        applyStimulus(2'b01, 2'b00, 2'b00, 2'b00);
        applyStimulus(2'b01, 2'b00, 2'b01, 2'b01);
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00);
        readCtr(0, 0, 2, "protocol_ch0_requests");
        readCtr(0, 2, 2, "protocol_ch0_hits");
        readCtr(0, 4, 2, "protocol_ch0_perf_err");
        readCtr(0, 3, 4, "protocol_ch0_lat_sum");
        readCtr(0, 6, 3, "protocol_ch0_lat_max");
        readCtr(1, 4, 1, "protocol_ch1_perf_err");
        readCtr(1, 1, 0, "protocol_ch1_replies");

        // Both channels miss at latency 5 on the same cycle
        pulseClear();
        repeat (4) applyStimulus(2'b01, 2'b10, 2'b00, 2'b00);
        applyStimulus(2'b01, 2'b10, 2'b11, 2'b00);
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00);
        checkOutput("dual_err", 32'(err), 0);
        readCtr(0, 1, 1, "dual_ch0_replies");
        readCtr(1, 1, 1, "dual_ch1_replies");
        readCtr(0, 3, 5, "dual_ch0_lat_sum");
        readCtr(1, 3, 5, "dual_ch1_lat_sum");
        pulseClear();
        readCtr(0, 1, 0, "cleared_ch0_replies");
        readCtr(1, 3, 0, "cleared_ch1_lat_sum");
        checkOutput("cleared_err", 32'(err), 0);

        // Twenty back-to-back hits saturate the 4-bit copy
        repeat (20) applyStimulus(2'b01, 2'b00, 2'b01, 2'b01);
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00);
        readCtr(0, 2, 20, "sat_wide_hits");
        checkOutput("sat_narrow_hits", 32'(rd_data4), 15);
        readCtr(0, 3, 20, "sat_wide_lat_sum");
        checkOutput("sat_narrow_lat_sum", 32'(rd_data4), 15);

        // Reset in the middle of a request, then re-arm while Rd is held
        applyStimulus(2'b01, 2'b00, 2'b00, 2'b00);
        checkOutput("rst_pre_busy", 32'(busy), 32'b01);
        rst = 1'b1;
        tick();
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_busy_narrow", 32'(busy4), 0);
        rst = 1'b0;
        tick();
        checkOutput("rearm_busy", 32'(busy), 32'b01);
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00);
        readCtr(0, 0, 1, "rearm_requests");
        readCtr(0, 1, 0, "rearm_replies");
        readCtr(0, 5, 1, "rearm_dropped");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
